// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-request record used by the
// writeback path and the register file itself.
package regfile_pkg;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } reg_write_t;
endpackage

// File: rtl/register_write_arbiter_fifo.sv
// Per-requester write queue: circular buffer with head peek and a per-entry
// valid/address view so the top can build the pending-write mask.
module reg_write_fifo #(
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             resetN,
    input  logic                             push,
    input  logic [ADDR_WIDTH-1:0]            pushAddr,
    input  logic [DATA_WIDTH-1:0]            pushData,
    input  logic                             pop,
    output logic                             full,
    output logic                             empty,
    output logic [ADDR_WIDTH-1:0]            headAddr,
    output logic [DATA_WIDTH-1:0]            headData,
    output logic [DEPTH-1:0]                 entryValid,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0] entryAddr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] addrMem [DEPTH];
    logic [DATA_WIDTH-1:0] dataMem [DEPTH];
    logic [PTR_W-1:0]      rdPtrReg;
    logic [PTR_W-1:0]      wrPtrReg;
    logic [CNT_W-1:0]      countReg;
    logic                  doPush;
    logic                  doPop;

    assign full     = (countReg == CNT_W'(DEPTH));
    assign empty    = (countReg == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headAddr = addrMem[rdPtrReg];
    assign headData = dataMem[rdPtrReg];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            addrMem[wrPtrReg] <= pushAddr;
            dataMem[wrPtrReg] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            rdPtrReg <= '0;
            wrPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) wrPtrReg <= wrPtrReg + 1'b1;
            if (doPop)  rdPtrReg <= rdPtrReg + 1'b1;
            countReg <= countReg + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gEntry
            logic [PTR_W-1:0] offset;
            assign offset         = PTR_W'(gi) - rdPtrReg;
            assign entryValid[gi] = ({1'b0, offset} < countReg);
            assign entryAddr[gi]  = addrMem[gi];
        end
    endgenerate
endmodule

// File: rtl/register_write_arbiter.sv
// Two-requester writeback arbiter: A/B queues drained round-robin into a
// registered register-file write stage, plus a pending-write hazard mask.
module register_write_arbiter #(
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     aValid,
    output logic                     aReady,
    input  logic [ADDR_WIDTH-1:0]    aRegister,
    input  logic [DATA_WIDTH-1:0]    aData,
    input  logic                     bValid,
    output logic                     bReady,
    input  logic [ADDR_WIDTH-1:0]    bRegister,
    input  logic [DATA_WIDTH-1:0]    bData,
    output logic [ADDR_WIDTH-1:0]    writeRegister,
    output logic [DATA_WIDTH-1:0]    writeData,
    output logic                     regWrite,
    output logic                     lastGrant,
    output logic [2**ADDR_WIDTH-1:0] pendingMask
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic                             aFull, aEmpty, bFull, bEmpty;
    logic [ADDR_WIDTH-1:0]            aHeadAddr, bHeadAddr, popAddr;
    logic [DATA_WIDTH-1:0]            aHeadData, bHeadData, popData;
    logic [DEPTH-1:0]                 aEntryValid, bEntryValid;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] aEntryAddr, bEntryAddr;
    logic                             grantB, popA, popB;
    logic [ADDR_WIDTH-1:0]            writeRegisterReg;
    logic [DATA_WIDTH-1:0]            writeDataReg;
    logic                             regWriteReg;
    logic                             lastGrantReg;
    logic [NUM_REGS-1:0]              maskNext;

    // Ready is held low throughout reset so nothing is accepted into a queue being flushed.
    assign aReady = resetN && !aFull;
    assign bReady = resetN && !bFull;

    reg_write_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) fifoA (
        .clk(clk), .resetN(resetN),
        .push(aValid && aReady), .pushAddr(aRegister), .pushData(aData),
        .pop(popA), .full(aFull), .empty(aEmpty),
        .headAddr(aHeadAddr), .headData(aHeadData),
        .entryValid(aEntryValid), .entryAddr(aEntryAddr)
    );

    reg_write_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) fifoB (
        .clk(clk), .resetN(resetN),
        .push(bValid && bReady), .pushAddr(bRegister), .pushData(bData),
        .pop(popB), .full(bFull), .empty(bEmpty),
        .headAddr(bHeadAddr), .headData(bHeadData),
        .entryValid(bEntryValid), .entryAddr(bEntryAddr)
    );

    // On a tie the requester not served last wins.
    assign grantB  = !bEmpty && (aEmpty || !lastGrantReg);
    assign popB    = grantB;
    assign popA    = !aEmpty && !grantB;
    assign popAddr = grantB ? bHeadAddr : aHeadAddr;
    assign popData = grantB ? bHeadData : aHeadData;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            writeRegisterReg <= '0;
            writeDataReg     <= '0;
            regWriteReg      <= 1'b0;
            lastGrantReg     <= 1'b1;
        end else if (popA || popB) begin
            writeRegisterReg <= popAddr;
            writeDataReg     <= popData;
            regWriteReg      <= (popAddr != '0);
            lastGrantReg     <= grantB;
        end else begin
            regWriteReg      <= 1'b0;
        end
    end

    always_comb begin
        maskNext = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (aEntryValid[i]) maskNext[aEntryAddr[i]] = 1'b1;
            if (bEntryValid[i]) maskNext[bEntryAddr[i]] = 1'b1;
        end
        if (regWriteReg) maskNext[writeRegisterReg] = 1'b1;
        maskNext[0] = 1'b0;
    end

    assign writeRegister = writeRegisterReg;
    assign writeData     = writeDataReg;
    assign regWrite      = regWriteReg;
    assign lastGrant     = lastGrantReg;
    assign pendingMask   = maskNext;
endmodule

// File: tb/tb_register_write_arbiter.sv
// Bench for register_write_arbiter: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_register_write_arbiter;
    import regfile_pkg::*;

    localparam int DEPTH = 2;

    logic                  clk = 1'b0;
    logic                  resetN = 1'b0;
    logic                  aValid = 1'b0, bValid = 1'b0;
    logic                  aReady, bReady;
    logic [ADDR_WIDTH-1:0] aRegister = '0, bRegister = '0;
    logic [DATA_WIDTH-1:0] aData = '0, bData = '0;
    logic [ADDR_WIDTH-1:0] writeRegister;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  regWrite;
    logic                  lastGrant;
    logic [NUM_REGS-1:0]   pendingMask;

    register_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetN(resetN),
        .aValid(aValid), .aReady(aReady), .aRegister(aRegister), .aData(aData),
        .bValid(bValid), .bReady(bReady), .bRegister(bRegister), .bData(bData),
        .writeRegister(writeRegister), .writeData(writeData), .regWrite(regWrite),
        .lastGrant(lastGrant), .pendingMask(pendingMask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two request queues, the write stage contents and who was served last.
    reg_write_t            qa[$], qb[$];
    reg_write_t            item;
    bit                    expRegWrite = 1'b0;
    logic [ADDR_WIDTH-1:0] expWriteReg = '0;
    logic [DATA_WIDTH-1:0] expWriteData = '0;
    bit                    expLastGrant = 1'b1;
    logic [DATA_WIDTH-1:0] modelRf [NUM_REGS];
    logic [DATA_WIDTH-1:0] dutRf   [NUM_REGS];

    initial for (int r = 0; r < NUM_REGS; r++) begin
        modelRf[r] = '0;
        dutRf[r]   = '0;
    end

    always @(posedge clk) begin
        bit aRoom, bRoom, takeA, takeB;
        if (expRegWrite) modelRf[expWriteReg] = expWriteData;
        if (regWrite)    dutRf[writeRegister] = writeData;
        if (!resetN) begin
            qa.delete();
            qb.delete();
            expRegWrite  = 1'b0;
            expWriteReg  = '0;
            expWriteData = '0;
            expLastGrant = 1'b1;
        end else begin
            aRoom = qa.size() < DEPTH;
            bRoom = qb.size() < DEPTH;
            if (qa.size() > 0 && qb.size() > 0) begin
                takeA = (expLastGrant == 1'b1);
                takeB = !takeA;
            end else begin
                takeA = qa.size() > 0;
                takeB = qb.size() > 0;
            end
            if (takeA || takeB) begin
                item = takeA ? qa.pop_front() : qb.pop_front();
                expWriteReg  = item.addr;
                expWriteData = item.data;
                expRegWrite  = (item.addr != 0);
                expLastGrant = takeB;
            end else begin
                expRegWrite = 1'b0;
            end
            if (aValid && aRoom) qa.push_back('{addr: aRegister, data: aData});
            if (bValid && bRoom) qb.push_back('{addr: bRegister, data: bData});
        end
    end

    always @(negedge clk) begin
        logic [NUM_REGS-1:0] expMask;
        if (checkEn) begin
            expMask = '0;
            foreach (qa[i]) expMask[qa[i].addr] = 1'b1;
            foreach (qb[i]) expMask[qb[i].addr] = 1'b1;
            if (expRegWrite) expMask[expWriteReg] = 1'b1;
            expMask[0] = 1'b0;
            check("regWrite", 64'(regWrite), 64'(expRegWrite));
            check("writeRegister", 64'(writeRegister), 64'(expWriteReg));
            check("writeData", 64'(writeData), 64'(expWriteData));
            check("lastGrant", 64'(lastGrant), 64'(expLastGrant));
            check("aReady", 64'(aReady), 64'(resetN && qa.size() < DEPTH));
            check("bReady", 64'(bReady), 64'(resetN && qb.size() < DEPTH));
            check("pendingMask", 64'(pendingMask), 64'(expMask));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        resetN = 1'b0;
        aValid = 1'b0;
        bValid = 1'b0;
        tick();
        check("rst_aReady_low", 64'(aReady), 64'd0);
        check("rst_bReady_low", 64'(bReady), 64'd0);
        check("rst_regWrite", 64'(regWrite), 64'd0);
        check("rst_mask", 64'(pendingMask), 64'd0);
        resetN = 1'b1;
        #1;
        check("rel_aReady_high", 64'(aReady), 64'd1);
        check("rel_bReady_high", 64'(bReady), 64'd1);
    endtask

    initial begin
        tick();
        doReset();
        checkEn = 1'b1;
        check("rst_writeRegister", 64'(writeRegister), 64'd0);
        check("rst_writeData", 64'(writeData), 64'd0);
        check("rst_lastGrant", 64'(lastGrant), 64'd1);

        // Single write from A.
        aValid = 1'b1; aRegister = 5'd5; aData = 32'h1234;
        tick();
        aValid = 1'b0;
        check("single_mask_c1", 64'(pendingMask[5]), 64'd1);
        check("single_noWrite_c1", 64'(regWrite), 64'd0);
        tick();
        check("single_regWrite", 64'(regWrite), 64'd1);
        check("single_reg", 64'(writeRegister), 64'd5);
        check("single_data", 64'(writeData), 64'h1234);
        check("single_mask_c2", 64'(pendingMask[5]), 64'd1);
        tick();
        check("single_done", 64'(regWrite), 64'd0);
        check("single_mask_clear", 64'(pendingMask), 64'd0);

        // Tie right after reset: A first, then B.
        doReset();
        aValid = 1'b1; aRegister = 5'd1; aData = 32'hA;
        bValid = 1'b1; bRegister = 5'd2; bData = 32'hB;
        tick();
        aValid = 1'b0; bValid = 1'b0;
        tick();
        check("tie_first_reg", 64'(writeRegister), 64'd1);
        check("tie_first_grant", 64'(lastGrant), 64'd0);
        tick();
        check("tie_second_reg", 64'(writeRegister), 64'd2);
        check("tie_second_grant", 64'(lastGrant), 64'd1);
        tick();

        // Back-pressure: B pushes r3, r4 while A streams.
        doReset();
        aValid = 1'b1; aRegister = 5'd10; aData = 32'h100;
        bValid = 1'b1; bRegister = 5'd3;  bData = 32'h33;
        tick();
        aRegister = 5'd11; aData = 32'h101;
        bRegister = 5'd4;  bData = 32'h44;
        tick();
        bValid = 1'b0;
        check("bp_bReady_low", 64'(bReady), 64'd0);
        check("bp_aReady_high", 64'(aReady), 64'd1);
        check("bp_first_A", 64'(writeRegister), 64'd10);
        for (int i = 0; i < 8; i++) begin
            aRegister = 5'(12 + i);
            aData     = 32'(32'h200 + i);
            tick();
            if (i == 0) check("bp_B_r3", 64'(writeRegister), 64'd3);
            if (i == 2) check("bp_B_r4", 64'(writeRegister), 64'd4);
        end
        aValid = 1'b0;
        repeat (4) tick();

        // Register 0 writes are swallowed.
        check("r0_aReady", 64'(aReady), 64'd1);
        aValid = 1'b1; aRegister = 5'd0; aData = 32'hFF;
        tick();
        aValid = 1'b0;
        check("r0_mask", 64'(pendingMask), 64'd0);
        tick();
        check("r0_noWrite", 64'(regWrite), 64'd0);
        aValid = 1'b1; aRegister = 5'd31; aData = 32'hFF;
        tick();
        aValid = 1'b0;
        tick();
        check("r31_write", 64'(regWrite), 64'd1);
        check("r31_reg", 64'(writeRegister), 64'd31);
        tick();

        // Reset with both queues full.
        aValid = 1'b1; bValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            aRegister = 5'(20 + i); aData = 32'hDEAD0000 + 32'(i);
            bRegister = 5'(24 + i); bData = 32'hBEEF0000 + 32'(i);
            tick();
        end
        resetN = 1'b0;
        tick();
        check("mid_rst_regWrite", 64'(regWrite), 64'd0);
        check("mid_rst_mask", 64'(pendingMask), 64'd0);
        check("mid_rst_aReady", 64'(aReady), 64'd0);
        check("mid_rst_bReady", 64'(bReady), 64'd0);
        aValid = 1'b0; bValid = 1'b0; resetN = 1'b1;
        #1;
        check("mid_rel_aReady", 64'(aReady), 64'd1);
        check("mid_rel_bReady", 64'(bReady), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_rst_flushed", 64'(regWrite), 64'd0);
        end

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            resetN    = ($urandom_range(0, 249) != 0);
            aValid    = ($urandom_range(0, 3) != 0);
            bValid    = ($urandom_range(0, 2) != 0);
            aRegister = 5'($urandom_range(0, NUM_REGS - 1));
            bRegister = 5'($urandom_range(0, NUM_REGS - 1));
            aData     = $urandom;
            bData     = $urandom;
            tick();
        end
        resetN = 1'b1; aValid = 1'b0; bValid = 1'b0;
        repeat (6) tick();

        for (int r = 1; r < NUM_REGS; r++)
            check("regfile_scoreboard", 64'(dutRf[r]), 64'(modelRf[r]));

        @(negedge clk);
        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
